// File: rtl/key_lock_pkg.sv
// Shared types and defaults for the key loader of the locked netlist.
package key_lock_pkg;

  localparam int unsigned KEY_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StShift  = 2'd1,
    StPar    = 2'd2,
    StCommit = 2'd3
  } state_e;

endpackage

// File: rtl/key_shift_loader.sv
// Serial key loader: shifts KEY_W bits MSB first, then commits them atomically to key_out.
// Build option KEY_PARITY_EN adds a trailing even-parity bit that must match before commit.
module key_shift_loader
  import key_lock_pkg::*;
#(
  parameter int unsigned KEY_W = KEY_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_start,
  input  logic             key_sin,
  input  logic             key_sin_valid,
  output logic             key_sin_ready,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic             busy,
  output logic             key_err
);

  localparam int unsigned      CNT_W    = $clog2(KEY_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(KEY_W - 1);

  state_e           state_q;
  logic [KEY_W-1:0] shreg_q;
  logic [CNT_W-1:0] cnt_q;
  logic             xfer;

  assign key_sin_ready = (state_q == StShift) || (state_q == StPar);
  assign busy          = (state_q != StIdle);
  assign xfer          = key_sin_valid && key_sin_ready;

`ifdef KEY_PARITY_EN
  logic err_q;
  assign key_err = err_q;
`else
  assign key_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      shreg_q   <= '0;
      cnt_q     <= '0;
      key_out   <= '0;
      key_valid <= 1'b0;
`ifdef KEY_PARITY_EN
      err_q     <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (load_start) begin
            shreg_q <= '0;
            cnt_q   <= '0;
            state_q <= StShift;
          end
        end
        StShift: begin
          // A restart wins over a bit offered in the same cycle.
          if (load_start) begin
            shreg_q <= '0;
            cnt_q   <= '0;
          end else if (xfer) begin
            shreg_q <= {shreg_q[KEY_W-2:0], key_sin};
            cnt_q   <= cnt_q + 1'b1;
            if (cnt_q == LAST_CNT) begin
`ifdef KEY_PARITY_EN
              state_q <= StPar;
`else
              state_q <= StCommit;
`endif
            end
          end
        end
        StPar: begin
`ifdef KEY_PARITY_EN
          if (load_start) begin
            shreg_q <= '0;
            cnt_q   <= '0;
            state_q <= StShift;
          end else if (xfer) begin
            if (key_sin == ^shreg_q) begin
              state_q <= StCommit;
            end else begin
              err_q   <= 1'b1;
              state_q <= StIdle;
            end
          end
`else
          state_q <= StIdle;
`endif
        end
        StCommit: begin
          key_out   <= shreg_q;
          key_valid <= 1'b1;
`ifdef KEY_PARITY_EN
          err_q     <= 1'b0;
`endif
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
